// File: rtl/mem_pkg.sv
// Shared widths and FSM state type for the line-granular main data memory.
package mem_pkg;
   localparam int LINE_W         = 128;
   localparam int MEM_ADDR_W     = 28;
   localparam int WORDS_PER_LINE = 4;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } mem_state_e;
endpackage

// File: rtl/mem_line_array.sv
// Line storage: one synchronous write port, one combinational read port.
// Contents are deliberately not reset.
module mem_line_array
   import mem_pkg::*;
#(
   parameter int DEPTH_LINES = 256,
   parameter int IDX_W       = $clog2(DEPTH_LINES)
) (
   input  logic              i_clock,
   input  logic              i_we,
   input  logic [IDX_W-1:0]  i_wr_idx,
   input  logic [LINE_W-1:0] i_wr_dat,
   input  logic [IDX_W-1:0]  i_rd_idx,
   output logic [LINE_W-1:0] o_rd_dat
);
   logic [LINE_W-1:0] r_mem [DEPTH_LINES];

   always_ff @(posedge i_clock) begin
      if (i_we) begin
         r_mem[i_wr_idx] <= i_wr_dat;
      end
   end

   assign o_rd_dat = r_mem[i_rd_idx];
endmodule

// File: rtl/data_main_memory.sv
// Fixed-latency line memory responder: LATENCY cycles per access, busywait high until the last.
// Requests are level-held; dropping both read and write mid-access aborts without storing.
module data_main_memory
   import mem_pkg::*;
#(
   parameter int LATENCY     = 5,
   parameter int DEPTH_LINES = 256,
   parameter int ADDR_W      = MEM_ADDR_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              read,
   input  logic              write,
   input  logic [ADDR_W-1:0] address,
   input  logic [LINE_W-1:0] writedata,
   output logic [LINE_W-1:0] readdata,
   output logic              busywait
);
   localparam int IDX_W = $clog2(DEPTH_LINES);
   localparam int CNT_W = $clog2(LATENCY);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

   mem_state_e        r_state;
   mem_state_e        w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              r_op_wr;
   logic [IDX_W-1:0]  r_idx;
   logic [LINE_W-1:0] r_wdata;
   logic [LINE_W-1:0] r_readdata;

   logic              w_valid;
   logic              w_abort;
   logic              w_busy;
   logic              w_complete;
   logic              w_rd_load;
   logic              w_mem_we;
   logic [IDX_W-1:0]  w_rd_idx;
   logic [LINE_W-1:0] w_rd_dat;
   logic              w_unused_addr;

   // Upper address bits alias onto the same lines.
   assign w_unused_addr = ^address[ADDR_W-1:IDX_W];

   assign w_valid  = read ^ write;
   assign w_abort  = !read && !write;
   assign busywait = w_busy;
   assign readdata = r_readdata;
   assign w_mem_we = w_complete && r_op_wr && !reset;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_busy      = 1'b0;
      w_complete  = 1'b0;
      w_rd_load   = 1'b0;
      w_rd_idx    = r_idx;
      case (r_state)
         IDLE: begin
            w_busy   = w_valid;
            w_rd_idx = address[IDX_W-1:0];
            if (w_valid) begin
               w_state_nxt = ACCESS;
               w_cnt_nxt   = CNT_W'(1);
               // With LATENCY==2 the accept edge is also the data-ready edge.
               w_rd_load   = read && (CNT_LAST == CNT_W'(1));
            end
         end
         ACCESS: begin
            w_busy = (r_cnt != CNT_LAST);
            if (w_abort) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
               w_complete  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
               w_rd_load = !r_op_wr && (w_cnt_nxt == CNT_LAST);
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_readdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_rd_load) begin
            r_readdata <= w_rd_dat;
         end
      end
   end

   // Request snapshot; later changes to address/data/op are ignored until completion.
   always_ff @(posedge clock) begin
      if (r_state == IDLE && w_valid) begin
         r_op_wr <= write;
         r_idx   <= address[IDX_W-1:0];
         r_wdata <= writedata;
      end
   end

   mem_line_array #(
      .DEPTH_LINES (DEPTH_LINES),
      .IDX_W       (IDX_W)
   ) u_array (
      .i_clock  (clock),
      .i_we     (w_mem_we),
      .i_wr_idx (r_idx),
      .i_wr_dat (r_wdata),
      .i_rd_idx (w_rd_idx),
      .o_rd_dat (w_rd_dat)
   );
endmodule
